// File: rtl/soc_defines.sv
// rtl/soc_defines.sv - shared SoC address map constants and byte-merge helper
package soc_defines;

    localparam logic [15:0] MMIO_BASE_DEFAULT = 16'h1FAF;
    localparam logic [31:0] KSEG_FOLD_MASK    = 32'h1FFF_FFFF;

    localparam logic [15:0] LED_OFF     = 16'h0000;
    localparam logic [15:0] SW_OFF      = 16'h0004;
    localparam logic [15:0] TIMER_OFF   = 16'h0008;
    localparam logic [15:0] COMPARE_OFF = 16'h000C;
    localparam logic [15:0] SCRATCH_OFF = 16'h0010;

    // Replace only the byte lanes whose enable bit is set
    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sram_bytewe.sv
// rtl/sram_bytewe.sv - single-port synchronous RAM with per-byte write enables
module sram_bytewe #(
    parameter int RAM_AW = 14
) (
    input  logic              clk,
    input  logic              en,
    input  logic [3:0]        we,
    input  logic [RAM_AW-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] mem [0:(1<<RAM_AW)-1];

    // Byte-lane writes, or a registered read when no lane is enabled; contents are never reset
    always_ff @(posedge clk) begin
        if (en) begin
            if (we != 4'b0000) begin
                for (int b = 0; b < 4; b++) begin
                    if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/data_sram_responder.sv
// rtl/data_sram_responder.sv - data SRAM responder: RAM, MMIO registers, timer interrupt
module data_sram_responder
    import soc_defines::*;
#(
    parameter int          RAM_AW    = 14,
    parameter logic [15:0] MMIO_BASE = MMIO_BASE_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    input  logic [15:0] sw_in,
    output logic [15:0] led_out,
    output logic        timer_int
);

    logic [31:0] phys;
    logic [15:0] off;
    logic        is_mmio;
    logic        req;
    logic        rd_req;
    logic        wr_req;
    logic [31:0] ram_rdata;
    logic [31:0] mmio_rd_val;

    logic [15:0] led_q, led_d;
    logic [31:0] timer_q, timer_d;
    logic [31:0] compare_q, compare_d;
    logic [31:0] scratch_q, scratch_d;
    logic        irq_q, irq_d;
    logic [31:0] mmio_rdata_q, mmio_rdata_d;
    logic        rsel_mmio_q, rsel_mmio_d;
    logic [15:0] sw_meta_q, sw_sync_q;

    // Requests arriving while reset is held are dropped entirely
    assign req     = data_sram_en & rst;
    assign rd_req  = req & (data_sram_wen == 4'b0000);
    assign wr_req  = req & (data_sram_wen != 4'b0000);
    assign phys    = data_sram_addr & KSEG_FOLD_MASK;
    assign is_mmio = (phys[31:16] == MMIO_BASE);
    assign off     = {phys[15:2], 2'b00};

    sram_bytewe #(.RAM_AW(RAM_AW)) u_ram (
        .clk   (clk),
        .en    (req & ~is_mmio),
        .we    (data_sram_wen),
        .addr  (phys[RAM_AW+1:2]),
        .wdata (data_sram_wdata),
        .rdata (ram_rdata)
    );

    // MMIO read mux; TIMER returns its value in the request cycle
    always_comb begin
        mmio_rd_val = 32'h0;
        case (off)
            LED_OFF:     mmio_rd_val = {16'h0, led_q};
            SW_OFF:      mmio_rd_val = {16'h0, sw_sync_q};
            TIMER_OFF:   mmio_rd_val = timer_q;
            COMPARE_OFF: mmio_rd_val = compare_q;
            SCRATCH_OFF: mmio_rd_val = scratch_q;
            default:     mmio_rd_val = 32'h0;
        endcase
    end

    // Next-state for registers: writes beat the timer increment, a COMPARE write beats a match
    always_comb begin
        led_d        = led_q;
        timer_d      = timer_q + 32'd1;
        compare_d    = compare_q;
        scratch_d    = scratch_q;
        irq_d        = irq_q | ((timer_q == compare_q) && (compare_q != 32'h0));
        mmio_rdata_d = mmio_rdata_q;
        rsel_mmio_d  = rsel_mmio_q;
        if (rd_req) begin
            rsel_mmio_d = is_mmio;
            if (is_mmio) mmio_rdata_d = mmio_rd_val;
        end
        if (wr_req && is_mmio) begin
            case (off)
                LED_OFF:     led_d     = 16'(byte_merge({16'h0, led_q}, data_sram_wdata, data_sram_wen));
                TIMER_OFF:   timer_d   = byte_merge(timer_q, data_sram_wdata, data_sram_wen);
                COMPARE_OFF: begin
                    compare_d = byte_merge(compare_q, data_sram_wdata, data_sram_wen);
                    irq_d     = 1'b0;
                end
                SCRATCH_OFF: scratch_d = byte_merge(scratch_q, data_sram_wdata, data_sram_wen);
                default:     ;
            endcase
        end
    end

    // Register state; reset selects the MMIO path with zero so rdata reads 0
    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q        <= 16'h0;
            timer_q      <= 32'h0;
            compare_q    <= 32'h0;
            scratch_q    <= 32'h0;
            irq_q        <= 1'b0;
            mmio_rdata_q <= 32'h0;
            rsel_mmio_q  <= 1'b1;
        end else begin
            led_q        <= led_d;
            timer_q      <= timer_d;
            compare_q    <= compare_d;
            scratch_q    <= scratch_d;
            irq_q        <= irq_d;
            mmio_rdata_q <= mmio_rdata_d;
            rsel_mmio_q  <= rsel_mmio_d;
        end
    end

    // Two-flop synchroniser for the asynchronous switches
    always_ff @(posedge clk) begin
        if (!rst) begin
            sw_meta_q <= 16'h0;
            sw_sync_q <= 16'h0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign data_sram_rdata = rsel_mmio_q ? mmio_rdata_q : ram_rdata;
    assign led_out         = led_q;
    assign timer_int       = irq_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// tb/tb_data_sram_responder.sv - randomized self-checking bench with behavioural model
module tb_data_sram_responder;

    logic        clk;
    logic        rst;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] sw_in;
    logic [15:0] led_out;
    logic        timer_int;

    int n_checks;
    int n_fail;

    data_sram_responder dut (
        .clk             (clk),
        .rst             (rst),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .sw_in           (sw_in),
        .led_out         (led_out),
        .timer_int       (timer_int)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Behavioural model state
    logic [31:0] mem_m [int];
    logic [31:0] m_rdata, m_led, m_timer, m_cmp, m_scr;
    bit          m_irq;
    logic [15:0] m_sw1, m_sw2;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
        logic [31:0] r;
        r = o;
        for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = n[8*b +: 8];
        return r;
    endfunction

    function automatic logic [31:0] model_mmio_read(input logic [15:0] o);
        case (o)
            16'h0000: return m_led;
            16'h0004: return {16'h0, m_sw2};
            16'h0008: return m_timer;
            16'h000C: return m_cmp;
            16'h0010: return m_scr;
            default:  return 32'h0;
        endcase
    endfunction

    task automatic model_step(input bit rn, input bit e, input logic [3:0] w,
                              input logic [31:0] a, input logic [31:0] d, input logic [15:0] sw);
        logic [31:0] phys;
        logic [15:0] o;
        bit          mmio;
        int          idx;
        logic [31:0] nt;
        bit          ni;
        if (!rn) begin
            m_rdata = 0; m_led = 0; m_timer = 0; m_cmp = 0; m_scr = 0;
            m_irq = 0; m_sw1 = 0; m_sw2 = 0;
            return;
        end
        phys = a & 32'h1FFF_FFFF;
        mmio = (phys[31:16] == 16'h1FAF);
        o    = phys[15:0] & 16'hFFFC;
        idx  = int'(phys[15:2]);
        nt   = m_timer + 32'd1;
        ni   = m_irq || ((m_timer == m_cmp) && (m_cmp != 0));
        if (e && w == 4'b0) begin
            m_rdata = mmio ? model_mmio_read(o) : mem_m[idx];
        end else if (e) begin
            if (mmio) begin
                case (o)
                    16'h0000: m_led = merge(m_led, d, w) & 32'h0000_FFFF;
                    16'h0008: nt = merge(m_timer, d, w);
                    16'h000C: begin m_cmp = merge(m_cmp, d, w); ni = 0; end
                    16'h0010: m_scr = merge(m_scr, d, w);
                    default: ;
                endcase
            end else begin
                mem_m[idx] = merge(mem_m.exists(idx) ? mem_m[idx] : 32'h0, d, w);
            end
        end
        m_timer = nt;
        m_irq   = ni;
        m_sw2   = m_sw1;
        m_sw1   = sw;
    endtask

    // One clock cycle: drive, advance model and DUT, compare every output
    task automatic step(input bit rn, input bit e, input logic [3:0] w,
                        input logic [31:0] a, input logic [31:0] d);
        rst = rn; en = e; wen = w; addr = a; wdata = d;
        model_step(rn, e, w, a, d, sw_in);
        @(posedge clk);
        #1;
        check_eq("rdata", rdata, m_rdata);
        check_eq("led_out", {16'h0, led_out}, m_led);
        check_eq("timer_int", {31'h0, timer_int}, {31'h0, m_irq});
    endtask

    function automatic logic [31:0] pool_addr(input int k);
        logic [31:0] seg;
        logic [31:0] hi;
        seg = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hA000_0000;
        case ($urandom_range(0, 3))
            0: hi = 32'h0000;
            1: hi = 32'h0001;
            2: hi = 32'h0F00;
            default: hi = 32'h1234;
        endcase
        return seg | (hi << 16) | (32'h100 + 32'(k) * 4) | 32'($urandom_range(0, 3));
    endfunction

    function automatic logic [31:0] mmio_addr(input logic [15:0] o);
        logic [31:0] seg;
        seg = ($urandom_range(0, 1) == 0) ? 32'h8000_0000 : 32'hA000_0000;
        return seg | 32'h1FAF_0000 | {16'h0, o};
    endfunction

    localparam int POOL = 8;

    initial begin
        logic [15:0] offs [7];
        logic [15:0] o;
        logic [31:0] d;
        int r;
        n_checks = 0;
        n_fail   = 0;
        offs = '{16'h0, 16'h4, 16'h8, 16'hC, 16'h10, 16'h14, 16'h20};
        sw_in = 16'h0;
        rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;

        // Reset state
        step(0, 1, 4'h0, 32'h8000_0000, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0);
        check_eq("reset_rdata", rdata, 32'h0);
        check_eq("reset_led", {16'h0, led_out}, 32'h0);
        check_eq("reset_int", {31'h0, timer_int}, 32'h0);

        // RAM byte write merge
        step(1, 1, 4'hF, 32'h8000_0100, 32'h1122_3344);
        step(1, 1, 4'h2, 32'h8000_0100, 32'h0000_AA00);
        step(1, 1, 4'h0, 32'h8000_0100, 32'h0);
        check_eq("ram_byte_merge", rdata, 32'h1122_AA44);

        // Back-to-back reads and kseg aliasing
        step(1, 1, 4'hF, 32'h8000_0000, 32'hCAFE_0001);
        step(1, 1, 4'hF, 32'h8000_0004, 32'hBEEF_0002);
        step(1, 1, 4'h0, 32'hA000_0000, 32'h0);
        check_eq("b2b_read0", rdata, 32'hCAFE_0001);
        step(1, 1, 4'h0, 32'h8000_0004, 32'h0);
        check_eq("b2b_read1", rdata, 32'hBEEF_0002);
        step(1, 1, 4'h0, 32'hA000_0004, 32'h0);
        check_eq("kseg1_alias", rdata, 32'hBEEF_0002);

        // LED and unmapped offset
        step(1, 1, 4'hF, 32'hBFAF_0000, 32'h0000_5A5A);
        check_eq("led_write", {16'h0, led_out}, 32'h0000_5A5A);
        step(1, 1, 4'hF, 32'hBFAF_0014, 32'hFFFF_FFFF);
        step(1, 1, 4'h0, 32'hBFAF_0014, 32'h0);
        check_eq("unmapped_read", rdata, 32'h0);

        // Timer compare interrupt
        step(1, 1, 4'hF, 32'hBFAF_000C, 32'h0000_0020);
        step(1, 1, 4'hF, 32'hBFAF_0008, 32'h0000_0010);
        for (int i = 0; i < 16; i++) step(1, 0, 4'h0, 32'h0, 32'h0);
        check_eq("int_not_yet", {31'h0, timer_int}, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);
        check_eq("int_rise", {31'h0, timer_int}, 32'h1);
        step(1, 1, 4'hF, 32'hBFAF_000C, 32'h0000_0050);
        check_eq("int_clear", {31'h0, timer_int}, 32'h0);
        step(1, 1, 4'hF, 32'hBFAF_0008, 32'h0000_0050);
        step(1, 1, 4'hF, 32'hBFAF_000C, 32'h0000_0050);
        check_eq("int_same_cycle_clear", {31'h0, timer_int}, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0);

        // Timer wrap
        step(1, 1, 4'hF, 32'hBFAF_0008, 32'hFFFF_FFFF);
        step(1, 1, 4'h0, 32'hBFAF_0008, 32'h0);
        check_eq("timer_max", rdata, 32'hFFFF_FFFF);
        step(1, 1, 4'h0, 32'hBFAF_0008, 32'h0);
        check_eq("timer_wrap", rdata, 32'h0);

        // Switch synchroniser, write ignored
        sw_in = 16'h00F0;
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 32'h0, 32'h0);
        step(1, 1, 4'h0, 32'hBFAF_0004, 32'h0);
        check_eq("switch_read", rdata, 32'h0000_00F0);
        step(1, 1, 4'hF, 32'hBFAF_0004, 32'h1234_FFFF);
        step(1, 1, 4'h0, 32'hBFAF_0004, 32'h0);
        check_eq("switch_ro", rdata, 32'h0000_00F0);

        // Mid-operation reset with interrupt pending
        step(1, 1, 4'hF, 32'hBFAF_0010, 32'hDEAD_BEEF);
        step(1, 1, 4'hF, 32'hBFAF_000C, 32'h0000_0008);
        step(1, 1, 4'hF, 32'hBFAF_0008, 32'h0000_0006);
        for (int i = 0; i < 3; i++) step(1, 0, 4'h0, 32'h0, 32'h0);
        check_eq("int_before_reset", {31'h0, timer_int}, 32'h1);
        step(1, 1, 4'h0, 32'hBFAF_0010, 32'h0);
        step(0, 1, 4'h0, 32'h8000_0100, 32'h0);
        check_eq("midreset_rdata", rdata, 32'h0);
        check_eq("midreset_led", {16'h0, led_out}, 32'h0);
        check_eq("midreset_int", {31'h0, timer_int}, 32'h0);
        step(1, 1, 4'h0, 32'h8000_0100, 32'h0);
        check_eq("ram_persists", rdata, 32'h1122_AA44);
        step(1, 1, 4'h0, 32'hBFAF_0008, 32'h0);
        check_eq("timer_after_reset", rdata, 32'h1);

        // Randomized traffic against the model
        for (int k = 0; k < POOL; k++) step(1, 1, 4'hF, pool_addr(k), $urandom);
        for (int n = 0; n < 800; n++) begin
            sw_in = 16'($urandom);
            r = $urandom_range(0, 9);
            o = offs[$urandom_range(0, 6)];
            case (r)
                0: step(1, 0, 4'($urandom), $urandom, $urandom);
                1, 2, 3: step(1, 1, 4'h0, pool_addr($urandom_range(0, POOL-1)), 32'h0);
                4, 5: step(1, 1, 4'($urandom_range(1, 15)), pool_addr($urandom_range(0, POOL-1)), $urandom);
                6, 7: step(1, 1, 4'h0, mmio_addr(o), 32'h0);
                8: begin
                    d = $urandom;
                    if (o == 16'hC && $urandom_range(0, 1) == 1) d = m_timer + 32'($urandom_range(1, 8));
                    if (o == 16'h8 && $urandom_range(0, 1) == 1) d = m_cmp - 32'($urandom_range(1, 8));
                    step(1, 1, ($urandom_range(0, 1) == 1) ? 4'hF : 4'($urandom_range(1, 15)), mmio_addr(o), d);
                end
                default: step(($urandom_range(0, 19) == 0) ? 1'b0 : 1'b1, 1, 4'h0, mmio_addr(o), 32'h0);
            endcase
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
